// File: rtl/decoder_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// decoder_scan_ctrl_if : control/sense/bitmap bundle of decoder_scan_ctrl
// Rev 1.0
// ============================================================================
interface decoder_scan_ctrl_if;
  logic        start;
  logic        mode;
  logic        stop;
  logic        sense;
  logic [3:0]  a;
  logic        busy;
  logic [15:0] sample_map;
  logic        map_valid;

  modport master (
    output start, mode, stop, sense,
    input  a, busy, sample_map, map_valid
  );

  modport slave (
    input  start, mode, stop, sense,
    output a, busy, sample_map, map_valid
  );
endinterface
`default_nettype wire

// File: rtl/decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// decoder_scan_ctrl : walks a decoder_4to16 select through 0..15, samples the
// sense return per row and publishes a 16-bit bitmap once per full pass.
// Rev 1.0
// ============================================================================
module decoder_scan_ctrl #(
  parameter int unsigned DWELL  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  decoder_scan_ctrl_if.slave bus
);

  localparam logic [7:0] c_last_cnt   = 8'(DWELL - 1);
  localparam logic [7:0] c_settle_cnt = 8'(SETTLE);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  a_q, a_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] map_q, map_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        mode_q, mode_d;
  logic        stop_pend_q, stop_pend_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= 4'd0;
      cnt_q       <= 8'd0;
      shadow_q    <= 16'h0000;
      map_q       <= 16'h0000;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      mode_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      map_q       <= map_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      mode_q      <= mode_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    map_d       = map_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    mode_d      = mode_q;
    stop_pend_d = stop_pend_q;

    case (state_q)
      ST_IDLE: begin
        a_d   = 4'd0;
        cnt_d = 8'd0;
        if (bus.start) begin
          state_d     = ST_SCAN;
          busy_d      = 1'b1;
          mode_d      = bus.mode;
          stop_pend_d = bus.stop;
        end
      end

      ST_SCAN: begin
        if (bus.stop) begin
          stop_pend_d = 1'b1;
        end
        if (cnt_q == c_settle_cnt) begin
          shadow_d[a_q] = bus.sense;
        end
        if (cnt_q == c_last_cnt) begin
          cnt_d = 8'd0;
          if (a_q != 4'hF) begin
            a_d = a_q + 4'd1;
          end else begin
            // shadow_d already holds a sample taken on this edge when SETTLE == DWELL-1
            a_d     = 4'd0;
            map_d   = shadow_d;
            valid_d = 1'b1;
            if (!(mode_q && !stop_pend_q)) begin
              state_d     = ST_IDLE;
              busy_d      = 1'b0;
              stop_pend_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.a          = a_q;
  assign bus.busy       = busy_q;
  assign bus.sample_map = map_q;
  assign bus.map_valid  = valid_q;

endmodule
`default_nettype wire
